shift_ctrl: RTL and testbench



---
 rtl/shift_ctrl_pkg.sv | 21 ++
 rtl/shift_ctrl_bitcnt.sv | 38 +++
 rtl/shift_ctrl.sv | 103 ++++++++++
 tb/tb_shift_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl_pkg
// Description : Shared types and constants for the shift-register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_ctrl_pkg;

  // Width of the shifted-bit counter (NBITS limited to 1..31)
  localparam int CNT_W = 5;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_SHIFT_HI = 2'd1,
    ST_SHIFT_LO = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage : shift_ctrl_pkg
`default_nettype wire

// File: rtl/shift_ctrl_bitcnt.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl_bitcnt
// Description : Shifted-bit counter with synchronous clear, increment enable
//               and terminal compare (count == NBITS).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ctrl_bitcnt
  import shift_ctrl_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_term
);

  localparam logic [CNT_W-1:0] C_NBITS = CNT_W'(NBITS);

  logic [CNT_W-1:0] r_count;

  // Counter register: reset/clear win over increment
  always_ff @(posedge clk) begin
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == C_NBITS);

endmodule : shift_ctrl_bitcnt
`default_nettype wire

// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_ctrl
// Description : Sequencer for a parallel-load / serial-shift register chain.
//               Issues one shld strobe, then NBITS serclk pulses, then done.
//               Optional macro SHIFT_CTRL_AUTO_RESTART_EN makes the transfer
//               free-running: done lasts one cycle, the next edge clears and
//               returns to LOAD.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  output logic             shld,
  output logic             serclk,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  state_t r_state;
  logic   r_shld;
  logic   r_serclk;
  logic   r_done;

  logic   w_cnt_inc;
  logic   w_cnt_clr;
  logic   w_cnt_term;

  // Count one bit per serclk rising edge, i.e. on each SHIFT_HI edge
  assign w_cnt_inc = (r_state == ST_SHIFT_HI);

`ifdef SHIFT_CTRL_AUTO_RESTART_EN
  // Leaving DONE starts a fresh transfer from a zero count
  assign w_cnt_clr = (r_state == ST_DONE);
`else
  assign w_cnt_clr = 1'b0;
`endif

  shift_ctrl_bitcnt #(
    .NBITS (NBITS)
  ) u_bitcnt (
    .clk     (clk),
    .i_rst   (reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_count (count),
    .o_term  (w_cnt_term)
  );

  // Sequencer FSM with registered strobe/clock/done outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_LOAD;
      r_shld   <= 1'b0;
      r_serclk <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shld   <= 1'b1;
          r_serclk <= 1'b0;
          r_state  <= ST_SHIFT_HI;
        end
        ST_SHIFT_HI: begin
          r_shld   <= 1'b0;
          r_serclk <= 1'b1;
          r_state  <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO: begin
          r_serclk <= 1'b0;
          // Counter already holds the post-increment value here
          if (w_cnt_term) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_SHIFT_HI;
          end
        end
        ST_DONE: begin
`ifdef SHIFT_CTRL_AUTO_RESTART_EN
          r_done  <= 1'b0;
          r_state <= ST_LOAD;
`else
          r_state <= ST_DONE;
`endif
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  assign shld   = r_shld;
  assign serclk = r_serclk;
  assign done   = r_done;

endmodule : shift_ctrl
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_ctrl
// Description : Directed self-checking bench for shift_ctrl (NBITS=8 and
//               NBITS=1 instances side by side). Honours
//               SHIFT_CTRL_AUTO_RESTART_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_ctrl;

  logic       clk;
  logic       reset;
  logic       shld8, serclk8, done8;
  logic [4:0] count8;
  logic       shld1, serclk1, done1;
  logic [4:0] count1;

  int n_checks;
  int n_errors;

  shift_ctrl #(.NBITS(8)) u_dut8 (
    .clk    (clk),
    .reset  (reset),
    .shld   (shld8),
    .serclk (serclk8),
    .count  (count8),
    .done   (done8)
  );

  shift_ctrl #(.NBITS(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .shld   (shld1),
    .serclk (serclk1),
    .count  (count1),
    .done   (done1)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected {shld, serclk, done, count[4:0]} after edge En (n=0: in reset)
  function automatic logic [7:0] f_expect(input int n, input int nb);
    int         e;
    logic       s, c, d;
    logic [4:0] k;
    s = 1'b0; c = 1'b0; d = 1'b0; k = 5'd0;
    e = n;
`ifdef SHIFT_CTRL_AUTO_RESTART_EN
    if (n > 0) e = ((n - 1) % (2 * nb + 2)) + 1;
    if (e == 2 * nb + 2) return 8'h00;
`endif
    if (e == 1) begin
      s = 1'b1;
    end else if (e >= 2 && e <= 2 * nb) begin
      c = ((e % 2) == 0);
      k = 5'(e / 2);
    end else if (e >= 2 * nb + 1) begin
      d = 1'b1;
      k = 5'(nb);
    end
    return {s, c, d, k};
  endfunction

  function automatic logic [7:0] pack8();
    return {shld8, serclk8, done8, count8};
  endfunction

  function automatic logic [7:0] pack1();
    return {shld1, serclk1, done1, count1};
  endfunction

  int  shld_cycles;
  int  ser_rises;
  int  overlap;
  logic prev_ser;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // ---- Reset held 10 cycles ----
    reset = 1'b1;
    repeat (10) step();
    check("reset_n8", 32'(pack8()), 32'(f_expect(0, 8)));
    check("reset_n1", 32'(pack1()), 32'(f_expect(0, 1)));
    reset = 1'b0;

    // ---- Full run E1..E40, per-edge checks and invariants ----
    shld_cycles = 0;
    ser_rises   = 0;
    overlap     = 0;
    prev_ser    = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step();
      check($sformatf("run_n8_E%0d", n), 32'(pack8()), 32'(f_expect(n, 8)));
      check($sformatf("run_n1_E%0d", n), 32'(pack1()), 32'(f_expect(n, 1)));
      if (n <= 17) begin
        if (shld8) shld_cycles++;
        if (serclk8 && !prev_ser) ser_rises++;
        if (shld8 && serclk8) overlap++;
      end
      prev_ser = serclk8;
    end
    check("inv_shld_cycles", 32'(shld_cycles), 32'd1);
    check("inv_serclk_rises", 32'(ser_rises), 32'd8);
    check("inv_overlap", 32'(overlap), 32'd0);

    // ---- Mid-shift reset at E9, held 2 cycles ----
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    for (int n = 1; n <= 9; n++) step();
    check("pre_rst_n8_E9", 32'(pack8()), 32'(f_expect(9, 8)));
    check("pre_rst_n8_E9_cnt", 32'(count8), 32'd4);
    reset = 1'b1;
    step();
    check("rst_edge1_n8", 32'(pack8()), 32'h00);
    check("rst_edge1_n1", 32'(pack1()), 32'h00);
    step();
    check("rst_edge2_n8", 32'(pack8()), 32'h00);
    reset = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      check($sformatf("restart_n8_E%0d", n), 32'(pack8()), 32'(f_expect(n, 8)));
      check($sformatf("restart_n1_E%0d", n), 32'(pack1()), 32'(f_expect(n, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the bench can never hang
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_shift_ctrl
`default_nettype wire
